// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and default width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor: d = x - y - b_in, b_out = borrow out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = x ^ y ^ b_in;
    assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: one result bit per cycle, LSB first, through a single
// full subtractor stage. Handshake: start is accepted only while busy=0 (IDLE);
// done pulses for one cycle when diff/b_out/ovf are loaded.
module serial_subtractor_4bit
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] x_sr_q;
    logic [WIDTH-1:0] y_sr_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
    logic             ovf_q;

    logic             fs_d;
    logic             fs_b;

    full_subtractor_1bit u_fs (
        .x     (x_sr_q[0]),
        .y     (y_sr_q[0]),
        .b_in  (borrow_q),
        .d     (fs_d),
        .b_out (fs_b)
    );

    // Result bits enter the minuend register from the top as its bits are consumed,
    // so after WIDTH shifts it holds the full difference without a separate register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_sr_q   <= '0;
            y_sr_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_sr_q   <= x;
                        y_sr_q   <= y;
                        borrow_q <= b_in;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SUB;
                    end
                end
                SUB: begin
                    x_sr_q   <= {fs_d, x_sr_q[WIDTH-1:1]};
                    y_sr_q   <= y_sr_q >> 1;
                    borrow_q <= fs_b;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        diff_q  <= {fs_d, x_sr_q[WIDTH-1:1]};
                        b_out_q <= fs_b;
                        // Signed overflow: borrow into the MSB differs from borrow out of it.
                        ovf_q   <= borrow_q ^ fs_b;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Scoreboard bench for serial_subtractor_4bit: directed cases, busy/reset handling
// and a randomized regression against an arithmetic reference model.
module tb_serial_subtractor_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         b_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] hold_diff = '0;
    logic         hold_bo = 1'b0;
    logic         hold_ov = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t ref_model(input int a, input int b, input int bi);
        exp_t e;
        int   r;
        int   sa;
        int   sb;
        int   sr;
        r  = a - b - bi;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sr = sa - sb - bi;
        e.diff = r[W-1:0];
        e.bo   = (r < 0);
        e.ov   = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
        e.cyc  = 0;
        return e;
    endfunction

    // Monitor: pops on every done; otherwise outputs must hold their last result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("diff", int'(diff), int'(mon_e.diff));
                    check("b_out", int'(b_out), int'(mon_e.bo));
                    check("ovf", int'(ovf), int'(mon_e.ov));
                    check("done_latency", cyc, mon_e.cyc);
                    hold_diff = mon_e.diff;
                    hold_bo   = mon_e.bo;
                    hold_ov   = mon_e.ov;
                end
            end else begin
                check("output_hold", int'({diff, b_out, ovf}), int'({hold_diff, hold_bo, hold_ov}));
            end
        end
    end

    // Driver: called and returns at a falling edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input bit pulse);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 1, 0);
        e = ref_model(int'(a), int'(b), int'(bi));
        e.cyc = cyc + 1 + W;
        exp_q.push_back(e);
        x = a;
        y = b;
        b_in = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = W'($urandom_range(0, (1 << W) - 1));
        y = W'($urandom_range(0, (1 << W) - 1));
        b_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("busy_after_accept", int'(busy), 1);
        if (pulse) begin
            @(negedge clk);
            start = 1'b1;
            x = '1;
            y = '0;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!done && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("done_timeout", 1, 0);
            start = 1'b1;
            x = '1;
            y = '0;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_b_out", int'(b_out), 0);
        check("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        do_op(4'd9, 4'd5, 1'b0, 1'b0);
        do_op(4'd5, 4'd9, 1'b0, 1'b0);
        do_op(4'd0, 4'd0, 1'b1, 1'b0);
        do_op(4'd8, 4'd1, 1'b0, 1'b0);
        do_op(4'd7, 4'd15, 1'b0, 1'b0);
        do_op(4'd3, 4'd1, 1'b0, 1'b1);

        // Abort mid-operation: reset on the second SUB cycle.
        do_op(4'd3, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        hold_diff = '0;
        hold_bo   = 1'b0;
        hold_ov   = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_diff", int'(diff), 0);
        check("abort_b_out", int'(b_out), 0);
        check("abort_ovf", int'(ovf), 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'd6, 4'd2, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                  1'($urandom_range(0, 1)), 1'b0);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
